// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: opcodes, FSM states, source decode.
// Replaces the legacy pipe_defs.vh header.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
    } src_use_t;

    function automatic src_use_t decode_src(logic [6:0] opc);
        src_use_t u;
        u = '0;
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                u.rs1_used = 1'b1;
                u.rs2_used = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: u.rs1_used = 1'b1;
            default: u = '0;
        endcase
        return u;
    endfunction

    function automatic logic is_cf_op(logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard sequencer: ID instruction, in-flight writers, control outputs.
interface hazard_ctrl_if;
    logic [31:0] id_idata;
    logic        id_is_nop;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        ex_we;
    logic        mem_we;
    logic        wb_we;
    logic        br_resolved;
    logic        pc_we;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_bubble;

    modport master (
        output id_idata, id_is_nop, ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we, br_resolved,
        input  pc_we, ifid_stall, ifid_flush, idex_bubble
    );

    modport slave (
        input  id_idata, id_is_nop, ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we, br_resolved,
        output pc_we, ifid_stall, ifid_flush, idex_bubble
    );
endinterface

// File: rtl/hazard_ctrl_cmp.sv
// Combinational RAW detector: compares up to two ID source regs against the EX/MEM/WB writers.
module hazard_cmp (
    input  logic [4:0] rs1,
    input  logic       rs1_used,
    input  logic [4:0] rs2,
    input  logic       rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_we,
    input  logic [4:0] mem_rd,
    input  logic       mem_we,
    input  logic [4:0] wb_rd,
    input  logic       wb_we,
    output logic       raw
);
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired zero, so a match on it is never a real dependency.
    function automatic logic src_hit(logic [4:0] rs, logic [4:0] ex_r, logic ex_w,
                                     logic [4:0] mem_r, logic mem_w,
                                     logic [4:0] wb_r, logic wb_w);
        return (rs != 5'd0) &&
               ((ex_w && (ex_r == rs)) || (mem_w && (mem_r == rs)) || (wb_w && (wb_r == rs)));
    endfunction

    assign rs1_hit = rs1_used && src_hit(rs1, ex_rd, ex_we, mem_rd, mem_we, wb_rd, wb_we);
    assign rs2_hit = rs2_used && src_hit(rs2, ex_rd, ex_we, mem_rd, mem_we, wb_rd, wb_we);
    assign raw     = rs1_hit || rs2_hit;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW stalls, control-flow fetch freeze,
// saturating stall/flush counters and a sticky protocol-error flag.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned BR_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     pipe,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err
);
    localparam int unsigned TMR_W = $clog2(BR_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(BR_TIMEOUT);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_set;
    logic             pc_we_c, ifid_stall_c, ifid_flush_c, idex_bubble_c;
    logic             raw;
    logic             is_cf;
    src_use_t         src_use;
    logic [6:0]       opcode;
    logic             unused_idata_bits;

    assign opcode  = pipe.id_idata[6:0];
    assign src_use = pipe.id_is_nop ? '0 : decode_src(opcode);
    assign is_cf   = !pipe.id_is_nop && is_cf_op(opcode);
    assign unused_idata_bits = ^{pipe.id_idata[31:25], pipe.id_idata[14:7]};

    hazard_cmp u_cmp (
        .rs1      (pipe.id_idata[19:15]),
        .rs1_used (src_use.rs1_used),
        .rs2      (pipe.id_idata[24:20]),
        .rs2_used (src_use.rs2_used),
        .ex_rd    (pipe.ex_rd),
        .ex_we    (pipe.ex_we),
        .mem_rd   (pipe.mem_rd),
        .mem_we   (pipe.mem_we),
        .wb_rd    (pipe.wb_rd),
        .wb_we    (pipe.wb_we),
        .raw      (raw)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        err_set       = 1'b0;
        pc_we_c       = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        case (state_q)
            RUN: begin
                if (pipe.br_resolved) err_set = 1'b1;
                if (raw) begin
                    ifid_stall_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (is_cf) begin
                    ifid_flush_c = 1'b1;
                    state_d      = BR_WAIT;
                    timer_d      = '0;
                end else begin
                    pc_we_c = 1'b1;
                end
            end
            BR_WAIT: begin
                ifid_flush_c = 1'b1;
                if (pipe.br_resolved) begin
                    pc_we_c = 1'b1;
                    state_d = RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TMR_LIMIT) begin
                        err_set = 1'b1;
                        state_d = RUN;
                        timer_d = '0;
                    end
                end
            end
            default: begin
                err_set = 1'b1;
                state_d = RUN;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, independent of the state register.
    assign pipe.pc_we       = reset && pc_we_c;
    assign pipe.ifid_stall  = reset && ifid_stall_c;
    assign pipe.ifid_flush  = reset && ifid_flush_c;
    assign pipe.idex_bubble = reset && idex_bubble_c;
    assign state            = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            timer_q   <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (err_set) err <= 1'b1;
            if (idex_bubble_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
